// File: rtl/timer_seq_pkg.sv
// timer_seq_pkg: shared types and defaults for the timer_sequencer block.
//   ts_state_e   - sequencer FSM states (IDLE, LOAD, RUN, GAP)
//   TS_W_DEF     - default duration width (matches the Timer n_i width)
//   TS_DEPTH_DEF - default number of queued durations
package timer_seq_pkg;

  localparam int unsigned TS_W_DEF     = 16;
  localparam int unsigned TS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } ts_state_e;

endpackage

// File: rtl/timer_seq_fifo.sv
// timer_seq_fifo: circular FIFO holding queued Timer durations.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   clr_i           - synchronous flush (drops all entries, ignores push)
//   push_i, data_i  - enqueue request and data; accepted when not full,
//                     or when full but a pop happens in the same cycle
//   pop_i           - dequeue the head entry (ignored when empty)
//   head_o          - current head entry
//   full_o, empty_o - occupancy flags, derived from registered pointers only
module timer_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_en_s;
  logic         rd_en_s;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign rd_en_s = pop_i && !empty_o && !clr_i;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign wr_en_s = push_i && !clr_i && (!full_o || rd_en_s);

  // Read/write pointer update, with flush returning both to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else if (clr_i) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_q <= wr_q;
      end
      if (rd_en_s) begin
        rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_q <= rd_q;
      end
    end
  end

  // Entry storage; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end else begin
      mem_q <= mem_q;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: plays a queue of durations back-to-back on one Timer.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   push_i, n_i         - enqueue a duration
//   full_o, empty_o     - queue occupancy after the current edge
//   overflow_o          - one-cycle pulse when a push is dropped
//   tmr_start_o         - Timer start level, high for the whole run
//   tmr_n_o             - Timer duration, last loaded value
//   tmr_end_i           - Timer end flag, only looked at in RUN
//   busy_o              - high in LOAD, RUN and GAP
//   done_o, done_cnt_o  - completion pulse and wrapping completion count
//   abort_i             - only with TIMER_SEQ_ABORT_EN defined: flush the
//                         queue, stop the Timer and return to IDLE
// Configuration macro: TIMER_SEQ_ABORT_EN (undefined by default).
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int unsigned DEPTH = TS_DEPTH_DEF,
  parameter int unsigned W     = TS_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
`ifdef TIMER_SEQ_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         push_i,
  input  logic [W-1:0] n_i,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o,
  output logic         tmr_start_o,
  output logic [W-1:0] tmr_n_o,
  input  logic         tmr_end_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [15:0]  done_cnt_o
);

  ts_state_e    state_q;
  logic         start_q;
  logic [W-1:0] tmr_n_q;
  logic         busy_q;
  logic         done_q;
  logic [15:0]  done_cnt_q;
  logic         overflow_q;

  logic         abort_s;
  logic         pop_s;
  logic         full_s;
  logic         empty_s;
  logic [W-1:0] head_s;

`ifdef TIMER_SEQ_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // LOAD is only entered with a non-empty queue, so the head is always valid.
  assign pop_s = (state_q == ST_LOAD) && !abort_s;

  timer_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (abort_s),
    .push_i  (push_i),
    .data_i  (n_i),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Flags come straight from the FIFO's registered pointers.
  assign full_o      = full_s;
  assign empty_o     = empty_s;
  assign overflow_o  = overflow_q;
  assign tmr_start_o = start_q;
  assign tmr_n_o     = tmr_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign done_cnt_o  = done_cnt_q;

  // Sequencer FSM with its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      tmr_n_q    <= {W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_cnt_q <= 16'd0;
      overflow_q <= 1'b0;
    end else if (abort_s) begin
      // Abort outranks push and tmr_end_i; the duration register is kept.
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      overflow_q <= push_i && full_s && !pop_s;
      case (state_q)
        ST_IDLE: begin
          start_q <= 1'b0;
          if (!empty_s) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          tmr_n_q <= head_s;
          busy_q  <= 1'b1;
          // A zero duration is consumed without ever starting the Timer.
          if (head_s == {W{1'b0}}) begin
            state_q <= ST_GAP;
            start_q <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_q <= 1'b1;
          if (tmr_end_i) begin
            state_q    <= ST_GAP;
            start_q    <= 1'b0;
            done_q     <= 1'b1;
            done_cnt_q <= done_cnt_q + 16'd1;
          end else begin
            state_q <= ST_RUN;
            start_q <= 1'b1;
          end
        end
        ST_GAP: begin
          // One low cycle so the Timer clears before the next start.
          start_q <= 1'b0;
          if (!empty_s) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed bench for timer_sequencer with a queue-based
// reference model, a simple Timer stand-in and literal spot checks.
module tb_timer_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_i = 1'b0;
  logic [15:0] n_i = 16'd0;
  logic        tmr_end_i = 1'b0;
`ifdef TIMER_SEQ_ABORT_EN
  logic        abort_i = 1'b0;
`endif
  logic        full_o, empty_o, overflow_o, tmr_start_o, busy_o, done_o;
  logic [15:0] tmr_n_o, done_cnt_o;

  timer_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef TIMER_SEQ_ABORT_EN
    .abort_i     (abort_i),
`endif
    .push_i      (push_i),
    .n_i         (n_i),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .overflow_o  (overflow_o),
    .tmr_start_o (tmr_start_o),
    .tmr_n_o     (tmr_n_o),
    .tmr_end_i   (tmr_end_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .done_cnt_o  (done_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: pending durations plus what the sequencer is doing.
  logic [15:0] mq[$];
  logic        m_start, m_busy, m_done, m_ovf;
  logic        m_pop_next;   // the next edge takes the head of the queue
  logic        m_running;    // an entry is being timed
  logic        m_settle;     // the mandatory low cycle after an entry
  logic [15:0] m_n, m_cnt;

  int vectors = 0;
  int miscompares = 0;
  int tcnt = 0;
  int hi, dn, ov, r1, g, r2, idx, found;
  logic st[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_start = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    m_pop_next = 1'b0; m_running = 1'b0; m_settle = 1'b0;
    m_n = 16'd0; m_cnt = 16'd0;
  endtask

  task automatic model_edge(input logic push, input logic [15:0] n,
                            input logic fin, input logic abort);
    int          sz;
    logic        pop_now;
    logic [15:0] v;
    sz      = mq.size();
    pop_now = m_pop_next;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
    if (abort) begin
      mq.delete();
      m_start = 1'b0; m_pop_next = 1'b0; m_running = 1'b0;
      m_settle = 1'b0; m_busy = 1'b0;
      return;
    end
    if (pop_now) begin
      v = mq.pop_front();
      m_n = v;
      m_pop_next = 1'b0;
      if (v == 16'd0) begin m_settle = 1'b1; m_start = 1'b0; end
      else begin m_running = 1'b1; m_start = 1'b1; end
    end else if (m_running) begin
      if (fin) begin
        m_done = 1'b1; m_cnt = m_cnt + 16'd1;
        m_running = 1'b0; m_start = 1'b0; m_settle = 1'b1;
      end
    end else begin
      // Waiting (idle or just finished): work queued before this edge
      // gets taken at the following edge.
      m_settle = 1'b0;
      m_pop_next = (sz > 0);
    end
    m_busy = m_pop_next | m_running | m_settle;
    if (push) begin
      if (sz < DEPTH || pop_now) mq.push_back(n);
      else m_ovf = 1'b1;
    end
  endtask

  function automatic logic abort_now();
`ifdef TIMER_SEQ_ABORT_EN
    return abort_i;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    check("full",     full_o,      (mq.size() == DEPTH));
    check("empty",    empty_o,     (mq.size() == 0));
    check("overflow", overflow_o,  m_ovf);
    check("start",    tmr_start_o, m_start);
    check("tmr_n",    tmr_n_o,     m_n);
    check("busy",     busy_o,      m_busy);
    check("done",     done_o,      m_done);
    check("done_cnt", done_cnt_o,  m_cnt);
  endtask

  // One clock: model steps on the edge, outputs compared 1 time unit later,
  // then the Timer stand-in raises end after tmr_n_o cycles of start.
  task automatic tick();
    logic ab;
    @(posedge clk);
    ab = abort_now();
    if (rst) model_reset();
    else model_edge(push_i, n_i, tmr_end_i, ab);
    #1;
    compare_all();
    if (tmr_start_o === 1'b1) tcnt++; else tcnt = 0;
    tmr_end_i = (tmr_start_o === 1'b1) && (tcnt == int'(tmr_n_o));
  endtask

  initial begin
    model_reset();
    // Reset values
    tick();
    check("rst_start", tmr_start_o, 1'b0);
    check("rst_n",     tmr_n_o,     16'd0);
    check("rst_full",  full_o,      1'b0);
    check("rst_empty", empty_o,     1'b1);
    check("rst_ovf",   overflow_o,  1'b0);
    check("rst_busy",  busy_o,      1'b0);
    check("rst_done",  done_o,      1'b0);
    check("rst_cnt",   done_cnt_o,  16'd0);
    tick();
    rst = 1'b0;

    // Idle for 20 cycles, with a stray tmr_end_i that must be ignored
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 5 && i < 8) tmr_end_i = 1'b1;
      tick();
      hi += int'(tmr_start_o);
    end
    check("idle_start_cycles", hi, 0);
    check("idle_empty", empty_o, 1'b1);
    check("idle_busy",  busy_o,  1'b0);
    check("idle_cnt",   done_cnt_o, 16'd0);

    // Single entry of 20
    push_i = 1'b1; n_i = 16'd20; tick(); push_i = 1'b0;
    check("t2_empty_k", empty_o, 1'b0);
    tick();
    check("t2_start_k1", tmr_start_o, 1'b0);
    check("t2_busy_k1",  busy_o, 1'b1);
    tick();
    check("t2_start_k2", tmr_start_o, 1'b1);
    check("t2_n",        tmr_n_o, 16'd20);
    hi = 1; dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      hi += int'(tmr_start_o);
      dn += int'(done_o);
    end
    check("t2_run_len", hi, 20);
    check("t2_done_pulses", dn, 1);
    check("t2_cnt", done_cnt_o, 16'd1);
    check("t2_idle", busy_o, 1'b0);

    // 5, 0, 7 on consecutive cycles
    st.delete();
    push_i = 1'b1; n_i = 16'd5; tick(); st.push_back(tmr_start_o);
    n_i = 16'd0; tick(); st.push_back(tmr_start_o);
    n_i = 16'd7; tick(); st.push_back(tmr_start_o);
    push_i = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); st.push_back(tmr_start_o); end
    idx = 0; r1 = 0; g = 0; r2 = 0;
    while (idx < st.size() && !st[idx]) idx++;
    while (idx < st.size() && st[idx]) begin r1++; idx++; end
    while (idx < st.size() && !st[idx]) begin g++; idx++; end
    while (idx < st.size() && st[idx]) begin r2++; idx++; end
    check("t3_run1", r1, 5);
    check("t3_gap", g, 4);
    check("t3_run2", r2, 7);
    check("t3_cnt", done_cnt_o, 16'd3);

    // Overflow while busy, then a full-queue push during a LOAD pop
    push_i = 1'b1; n_i = 16'd100; tick(); push_i = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin push_i = 1'b1; n_i = 16'd3; tick(); end
    push_i = 1'b0;
    check("t4_full", full_o, 1'b1);
    push_i = 1'b1; n_i = 16'd9; tick(); push_i = 1'b0;
    check("t4_ovf_pulse", overflow_o, 1'b1);
    check("t4_full_after_drop", full_o, 1'b1);
    ov = 1;
    for (int i = 0; i < 5; i++) begin tick(); ov += int'(overflow_o); end
    check("t4_ovf_count", ov, 1);
    found = 0;
    for (int j = 0; j < 200 && found == 0; j++) begin
      if (m_pop_next) found = 1; else tick();
    end
    check("t4_reach_load", found, 1);
    push_i = 1'b1; n_i = 16'd11; tick(); push_i = 1'b0;
    check("t4_pop_push_ovf", overflow_o, 1'b0);
    check("t4_pop_push_full", full_o, 1'b1);

    // Reset in the middle of a run with two entries still queued
    found = 0;
    for (int j = 0; j < 100 && found == 0; j++) begin
      if (m_running && mq.size() == 2) found = 1; else tick();
    end
    check("t5_reach_run", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_start", tmr_start_o, 1'b0);
    check("t5_async_empty", empty_o, 1'b1);
    check("t5_async_cnt",   done_cnt_o, 16'd0);
    check("t5_async_busy",  busy_o, 1'b0);
    model_reset();
    tcnt = 0; tmr_end_i = 1'b0;
    tick();
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 30; i++) begin tick(); hi += int'(tmr_start_o); end
    check("t5_no_runs", hi, 0);
    check("t5_empty", empty_o, 1'b1);

`ifdef TIMER_SEQ_ABORT_EN
    // Abort coincident with tmr_end_i and a push
    push_i = 1'b1; n_i = 16'd6; tick();
    n_i = 16'd4; tick(); push_i = 1'b0;
    found = 0;
    for (int j = 0; j < 20 && found == 0; j++) begin
      if (m_running) found = 1; else tick();
    end
    check("t6_reach_run", found, 1);
    abort_i = 1'b1; tmr_end_i = 1'b1; push_i = 1'b1; n_i = 16'd8;
    tick();
    abort_i = 1'b0; push_i = 1'b0;
    check("t6_done", done_o, 1'b0);
    check("t6_cnt", done_cnt_o, 16'd0);
    check("t6_busy", busy_o, 1'b0);
    check("t6_empty", empty_o, 1'b1);
    check("t6_start", tmr_start_o, 1'b0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin tick(); hi += int'(tmr_start_o); end
    check("t6_no_runs", hi, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Command-side driver for the 16-bit countdown Timer: accepts a queue of durations and plays them back-to-back. It drives the Timer's start and duration inputs, watches its end flag, and re-arms it for the next entry. It sits between control logic (which pushes durations) and one Timer instance, replacing hand-sequenced `start_i`/`n_i` toggling.

## Interface
Parameters:
- `DEPTH`, 4: queue entries, power of two, ≥2.
- `W`, 16: duration width; matches Timer `n_i`.

Ports:
- `clk` in 1: the one clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `push_i` in 1: enqueue `n_i` this cycle.
- `n_i` in W: duration to enqueue.
- `full_o` out 1: queue full.
- `empty_o` out 1: queue empty.
- `overflow_o` out 1: one-cycle pulse when a push is dropped.
- `tmr_start_o` out 1: to Timer `start_i`; level, held high for the whole run.
- `tmr_n_o` out W: to Timer `n_i`; stable while `tmr_start_o` = 1.
- `tmr_end_i` in 1: from Timer `curr_end_q`.
- `busy_o` out 1: high in LOAD, RUN and GAP.
- `done_o` out 1: one-cycle pulse per completed entry.
- `done_cnt_o` out 16: completed-entry counter.

## Operation
- Queue: FIFO of W-bit entries. A push when not full writes the entry. A push when full is dropped and `overflow_o` pulses, unless a pop happens in the same cycle, in which case the push is accepted. Push and pop in the same cycle leave the occupancy unchanged.
- FSM states: IDLE, LOAD, RUN, GAP.
  - IDLE: if queue is non-empty, go to LOAD.
  - LOAD: pop the head into `tmr_n_o`. If the value is 0, discard it, leave `tmr_start_o` low, and go to GAP. Otherwise go to RUN.
  - RUN: `tmr_start_o` = 1. When `tmr_end_i` = 1, pulse `done_o`, increment `done_cnt_o`, and go to GAP.
  - GAP: `tmr_start_o` = 0 for exactly one cycle so the Timer clears. Then go to LOAD if the queue is non-empty, else to IDLE.
- `tmr_end_i` is ignored outside RUN.
- `tmr_n_o` holds its last loaded value in IDLE and GAP.
- `done_cnt_o` wraps from 0xFFFF to 0.
- Reset mid-operation: the queue is emptied, FSM goes to IDLE, and all outputs return to reset values. The in-flight entry is lost.

## Timing
- Reset values: `tmr_start_o` 0, `tmr_n_o` 0, `full_o` 0, `empty_o` 1, `overflow_o` 0, `busy_o` 0, `done_o` 0, `done_cnt_o` 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Push at edge k into an empty queue with FSM in IDLE:
  - `empty_o` = 0 after edge k.
  - FSM is in LOAD after edge k+1.
  - `tmr_start_o` = 1 after edge k+2.
- `tmr_end_i` sampled high at edge e: `done_o` = 1 and `tmr_start_o` = 0 after edge e. `done_o` is high for one cycle only.
- Back-to-back entries: `tmr_start_o` is low for exactly 2 cycles between runs (GAP, then LOAD), then rises for the next entry.
- Zero-length entry: costs 2 cycles (LOAD, GAP), produces no `done_o`, and leaves `done_cnt_o` unchanged.
- `full_o` and `empty_o` reflect occupancy after the current edge.

## Configuration
- `TIMER_SEQ_ABORT_EN` defined:
  - Adds input `abort_i` (1 bit).
  - `abort_i` = 1 at an edge empties the queue, drives `tmr_start_o` to 0, and forces IDLE. No `done_o` pulse; `done_cnt_o` unchanged.
  - Abort has priority over push and over `tmr_end_i` in the same cycle.
- `TIMER_SEQ_ABORT_EN` undefined: `abort_i` port and all abort logic are absent; behaviour is otherwise identical.

## Structure
- Package `timer_seq_pkg`: FSM state enum (IDLE, LOAD, RUN, GAP), default width constant 16, default depth constant 4.
- Sub-module `timer_seq_fifo`: parameterised by DEPTH and W. Pointer-based circular FIFO with one extra pointer bit for full/empty, exposing push, pop, head data, `full`, `empty`.
- Top level: FSM, output registers, done counter.

## Test plan
- Reset, no push for 20 cycles -> `tmr_start_o` = 0, `empty_o` = 1, `busy_o` = 0, `done_cnt_o` = 0 throughout.
- Push 20 at cycle 0; Timer model ends 20 cycles after start -> `tmr_n_o` = 20, `tmr_start_o` high from cycle 2, one `done_o` pulse, `done_cnt_o` = 1, FSM back in IDLE.
- Push 5, 0, 7 on consecutive cycles -> runs of 5 then 7, `tmr_start_o` low for 4 cycles between runs (2 for the skipped 0, 2 for the normal gap), `done_cnt_o` = 2.
- Push 5 entries with DEPTH = 4 while the FSM is busy -> 5th push dropped, one `overflow_o` pulse, `full_o` = 1. Same push coincident with a LOAD pop -> accepted, no overflow.
- Assert `rst` mid-RUN with 2 entries queued -> same cycle: `tmr_start_o` = 0, `empty_o` = 1, `done_cnt_o` = 0. After release, no further runs without new pushes.
- With `TIMER_SEQ_ABORT_EN`: `abort_i` and `tmr_end_i` in the same cycle -> no `done_o`, `done_cnt_o` unchanged, FSM in IDLE, `empty_o` = 1.
